// File: rtl/xorshift_stream_checker.sv
// Receive-side checker for the xorshift32 test pattern: compares each accepted word
// against a locally regenerated sequence that reseeds at every block boundary.
module xorshift_stream_checker #(
  parameter logic [31:0] SEED       = 32'd123456789,
  parameter int unsigned BLOCK_LOG2 = 10,
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  ok,
  output logic [ERR_W-1:0]      err_count,
  output logic [BLOCK_LOG2-1:0] first_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned    BLK_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

  function automatic logic [31:0] xorshift(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  logic [1:0]            state, state_d;
  logic [BLOCK_LOG2-1:0] index, index_d;
  logic [BLK_W-1:0]      block, block_d;
  logic [31:0]           gen, gen_d;
  logic                  error_d;
  logic [ERR_W-1:0]      err_count_d;
  logic [BLOCK_LOG2-1:0] first_err_d;

  logic hs, start_run, last_hs;

  assign hs        = in_valid && in_ready;
  assign start_run = start && (state != ST_RUN);
  assign last_hs   = hs && (&index) && (block == LAST_BLK);

  // Next-state and datapath update
  always_comb begin
    state_d     = state;
    index_d     = index;
    block_d     = block;
    gen_d       = gen;
    error_d     = error;
    err_count_d = err_count;
    first_err_d = first_err;

    case (state)
      ST_IDLE: if (start)   state_d = ST_RUN;
      ST_RUN:  if (last_hs) state_d = ST_DONE;
      ST_DONE: if (start)   state_d = ST_RUN;
      default:              state_d = ST_IDLE;
    endcase

    if (start_run) begin
      index_d     = '0;
      block_d     = '0;
      gen_d       = SEED;
      error_d     = 1'b0;
      err_count_d = '0;
      first_err_d = '0;
    end else if (hs) begin
      if (in_data != gen) begin
        error_d = 1'b1;
        if (!(&err_count)) err_count_d = err_count + ERR_W'(1);
        if (!error)        first_err_d = index;
      end
      index_d = index + BLOCK_LOG2'(1);
      if (&index) begin
        gen_d   = SEED;
        block_d = block + BLK_W'(1);
      end else begin
        gen_d = xorshift(gen);
      end
    end
  end

  // Outputs are registered from the next-state values so they align with the state change
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      index     <= '0;
      block     <= '0;
      gen       <= SEED;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      ok        <= 1'b0;
      err_count <= '0;
      first_err <= '0;
    end else begin
      state     <= state_d;
      index     <= index_d;
      block     <= block_d;
      gen       <= gen_d;
      in_ready  <= (state_d == ST_RUN);
      busy      <= (state_d == ST_RUN);
      done      <= (state_d == ST_DONE);
      error     <= error_d;
      ok        <= (state_d == ST_DONE) && !error_d;
      err_count <= err_count_d;
      first_err <= first_err_d;
    end
  end

endmodule

// File: tb/tb_xorshift_stream_checker.sv
// Randomized self-checking bench for xorshift_stream_checker against a table-driven
// reference of the expected stream and a per-run error tally.
module tb_xorshift_stream_checker;

  localparam int ERR_W_TB = 4;
  localparam int BLK_LEN  = 1024;
  localparam int NBLK     = 4;
  localparam int TOTAL    = BLK_LEN * NBLK;
  localparam logic [31:0] SEED_TB = 32'd123456789;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready, busy, done, error, ok;
  logic [ERR_W_TB-1:0] err_count;
  logic [9:0]  first_err;

  xorshift_stream_checker #(
    .SEED(SEED_TB), .BLOCK_LOG2(10), .NUM_BLOCKS(NBLK), .ERR_W(ERR_W_TB)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .error(error), .ok(ok),
    .err_count(err_count), .first_err(first_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ref_tbl [BLK_LEN];

  // Reference tally for the current run
  logic m_err;
  int   m_cnt;
  int   m_first;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_for(input int w, input int mode);
    logic [31:0] d;
    d = ref_tbl[w % BLK_LEN];
    case (mode)
      1: if (w == 2 * BLK_LEN + 5) d = d ^ 32'h1;
      2: d = ~d;
      3: if (w == 10) d = d ^ 32'h8000_0000;
      default: ;
    endcase
    return d;
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the start edge
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy",     32'(busy),      32'd1);
    chk("start_in_ready", 32'(in_ready),  32'd1);
    chk("start_done",     32'(done),      32'd0);
    chk("start_error",    32'(error),     32'd0);
    chk("start_errcnt",   32'(err_count), 32'd0);
  endtask

  task automatic feed(input int mode, input int gap_pct, input int start_at, input int stop_at);
    int  w;
    int  cyc;
    bit  hs;
    bit  probe;
    w = 0; cyc = 0;
    m_err = 1'b0; m_cnt = 0; m_first = 0;
    while (w < TOTAL && cyc < 20000 && w != stop_at) begin
      in_valid = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? word_for(w, mode) : $urandom;
      start    = (w == start_at);
      hs       = in_valid && in_ready;
      probe    = hs && mode == 1 && w == 2 * BLK_LEN + 5;
      if (probe) chk("err_before_bad", 32'(error), 32'd0);
      if (hs) begin
        if (in_data != ref_tbl[w % BLK_LEN]) begin
          if (!m_err) m_first = w % BLK_LEN;
          m_err = 1'b1;
          if (m_cnt < (1 << ERR_W_TB) - 1) m_cnt++;
        end
        w++;
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
      if (probe) begin
        chk("err_after_bad",   32'(error),     32'd1);
        chk("first_err_early", 32'(first_err), 32'd5);
      end
      if (start && w < TOTAL) chk("busy_after_midstart", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (stop_at < 0) chk("words_accepted", 32'(w), 32'(TOTAL));
  endtask

  task automatic check_end();
    chk("end_done",     32'(done),      32'd1);
    chk("end_ok",       32'(ok),        32'(!m_err));
    chk("end_error",    32'(error),     32'(m_err));
    chk("end_errcnt",   32'(err_count), 32'(m_cnt));
    chk("end_busy",     32'(busy),      32'd0);
    chk("end_in_ready", 32'(in_ready),  32'd0);
    if (m_err) chk("end_first_err", 32'(first_err), 32'(m_first));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready),  32'd0);
    chk({tag, "_busy"},     32'(busy),      32'd0);
    chk({tag, "_done"},     32'(done),      32'd0);
    chk({tag, "_error"},    32'(error),     32'd0);
    chk({tag, "_ok"},       32'(ok),        32'd0);
    chk({tag, "_errcnt"},   32'(err_count), 32'd0);
    chk({tag, "_first"},    32'(first_err), 32'd0);
  endtask

  initial begin
    logic [31:0] x;
    resetn   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    x = SEED_TB;
    for (int i = 0; i < BLK_LEN; i++) begin
      ref_tbl[i] = x;
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
    end

    #12;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // 1: clean run
    do_start();
    feed(0, 0, -1, -1);
    check_end();

    // 2: single bit flip in block 2 word 5
    do_start();
    feed(1, 0, -1, -1);
    check_end();

    // 3: random valid gaps with correct data
    do_start();
    feed(0, 50, -1, -1);
    check_end();

    // 4: every word wrong, counter saturates
    do_start();
    feed(2, 0, -1, -1);
    check_end();

    // 5: start mid-run is ignored; re-arm after done clears results
    do_start();
    feed(3, 20, 100, -1);
    check_end();
    do_start();

    // 6: async reset mid-run with error set, then clean run
    feed(3, 0, -1, BLK_LEN + 700);
    chk("pre_reset_error", 32'(error), 32'd1);
    #2 resetn = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_start();
    feed(0, 30, -1, -1);
    check_end();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
